// File: rtl/mboot_reboot_ctrl.sv
// Reboot sequencer for EG_LOGIC_MBOOT: arbitrates keys vs host, holds the address
// stable through a setup window and a fixed-width active-low reboot pulse.
module mboot_reboot_ctrl #(
    parameter int         DEBOUNCE_CYC = 240000,
    parameter int         SETUP_CYC    = 16,
    parameter int         PULSE_CYC    = 8,
    parameter logic [7:0] IMG0_ADDR    = 8'h00,
    parameter logic [7:0] IMG1_ADDR    = 8'h0a,
    parameter logic [7:0] IMG2_ADDR    = 8'h14
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       key_sel,
    input  logic       key_go,
    input  logic       host_req,
    input  logic [7:0] host_addr,
    output logic       host_ack,
    output logic       busy,
    output logic [1:0] sel_idx,
    output logic [7:0] mboot_addr,
    output logic       mboot_rebootn,
    output logic [2:0] RGB_LED
);

    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SEQ_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SEQ_W-1:0] SETUP_LAST = SEQ_W'(SETUP_CYC - 1);
    localparam logic [SEQ_W-1:0] PULSE_LAST = SEQ_W'(PULSE_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Key bit 0 is key_sel, bit 1 is key_go.
    logic [1:0]      r_key_meta;
    logic [1:0]      r_key_sync;
    logic [1:0]      r_key_db;
    logic [1:0]      r_key_db_d;
    logic [DB_W-1:0] r_db_cnt [2];

    logic [1:0]       r_state;
    logic [SEQ_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [7:0]       r_addr;
    logic             r_ack;
    logic             r_busy;
    logic             r_rebootn;
    logic [2:0]       r_led;

    logic [1:0]       w_press;
    logic [7:0]       w_img_addr;
    logic [1:0]       w_state_nxt;
    logic [SEQ_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [7:0]       w_addr_nxt;
    logic             w_ack_nxt;

    function automatic logic [7:0] img_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    img_addr = IMG0_ADDR;
            2'd1:    img_addr = IMG1_ADDR;
            2'd2:    img_addr = IMG2_ADDR;
            default: img_addr = IMG0_ADDR;
        endcase
    endfunction

    function automatic logic [2:0] led_for(input logic [1:0] st, input logic [1:0] idx);
        case (st)
            ST_IDLE: begin
                case (idx)
                    2'd0:    led_for = 3'b001;
                    2'd1:    led_for = 3'b010;
                    2'd2:    led_for = 3'b100;
                    default: led_for = 3'b001;
                endcase
            end
            ST_ARM:  led_for = 3'b111;
            ST_FIRE: led_for = 3'b111;
            ST_HOLD: led_for = 3'b000;
            default: led_for = 3'b001;
        endcase
    endfunction

    // Two-flop synchronizers for both raw buttons; released level is 1.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_key_meta <= 2'b11;
            r_key_sync <= 2'b11;
        end else begin
            r_key_meta <= {key_go, key_sel};
            r_key_sync <= r_key_meta;
        end
    end

    // Debouncers: level flips after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_key_db   <= 2'b11;
            r_key_db_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_key_db_d <= r_key_db;
            for (int i = 0; i < 2; i++) begin
                if (r_key_sync[i] == r_key_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_key_db[i] <= r_key_sync[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_press    = r_key_db_d & ~r_key_db;
    assign w_img_addr = img_addr(r_sel);

    // Next-state logic; host wins over a simultaneous key_go press.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_addr_nxt  = r_addr;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[0]) begin
                    w_sel_nxt = (r_sel == 2'd2) ? 2'd0 : (r_sel + 2'd1);
                end else begin
                    w_sel_nxt = r_sel;
                end
                if (host_req) begin
                    w_state_nxt = ST_ARM;
                    w_addr_nxt  = host_addr;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_press[1]) begin
                    w_state_nxt = ST_ARM;
                    w_addr_nxt  = w_img_addr;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ST_FIRE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + SEQ_W'(1);
                end
            end
            ST_FIRE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + SEQ_W'(1);
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_HOLD;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; outputs are decoded from next state so they align with it.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sel     <= 2'd0;
            r_addr    <= IMG0_ADDR;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_rebootn <= 1'b1;
            r_led     <= 3'b001;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_addr    <= w_addr_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_rebootn <= (w_state_nxt != ST_FIRE);
            r_led     <= led_for(w_state_nxt, w_sel_nxt);
        end
    end

    assign host_ack      = r_ack;
    assign busy          = r_busy;
    assign sel_idx       = r_sel;
    assign mboot_addr    = r_addr;
    assign mboot_rebootn = r_rebootn;
    assign RGB_LED       = r_led;

endmodule
